// File: rtl/retrosoc_flash_pkg.sv
// Shared constants and types for the boot-flash read sequencer.
package retrosoc_flash_pkg;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;

  // 64 serial bits per transaction: 8 command, 24 address, 32 data
  localparam int unsigned BIT_CNT_W = 7;
  localparam logic [BIT_CNT_W-1:0] LAST_CMD_BIT  = 7'd7;
  localparam logic [BIT_CNT_W-1:0] LAST_ADDR_BIT = 7'd31;
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = 7'd63;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StDone,
    StGap
  } flash_state_e;

  // Bytes arrive first-to-last into bits [31:0] MSB-down; the word is little-endian.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_flash_rd_ctrl_if.sv
// Request/response bundle between the flash-fetch logic and the read sequencer.
interface spi_flash_rd_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/spi_sck_gen.sv
// SCK generator: toggles every CLK_DIV enabled cycles, flags the edge it is about to make.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic sck_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            sck_q;
  logic            half_done;

  assign half_done  = en_i && (cnt_q == CntW'(CLK_DIV - 1));
  // Strobes mark the clk_i edge at which sck_q changes
  assign rise_stb_o = half_done && !sck_q;
  assign fall_stb_o = half_done && sck_q;
  assign sck_o      = sck_q;

  // Half-period counter and SCK register, held cleared while disabled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (half_done) begin
      cnt_q <= '0;
      sck_q <= !sck_q;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/spi_flash_rd_ctrl.sv
// Single-bit mode-0 SPI flash word reader: 0x03 + 24-bit address, four bytes back.
module spi_flash_rd_ctrl
  import retrosoc_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_IDLE = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  spi_flash_rd_ctrl_if.slave        bus,
  output logic                      flash_csb_o,
  output logic                      flash_clk_o,
  output logic                      flash_mosi_o,
  input  logic                      flash_miso_i
);

  localparam int unsigned GapW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

  flash_state_e         state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [GapW-1:0]      gap_cnt_q;
  logic [31:0]          tx_q;
  logic [31:0]          rx_q;
  logic [31:0]          rsp_data_q;
  logic                 csb_q;
  logic                 accept;
  logic                 shifting;
  logic                 last_gap;
  logic                 rise_stb;
  logic                 fall_stb;
  logic                 unused_addr;

  assign accept      = bus.req_valid && (state_q == StIdle);
  assign shifting    = state_q inside {StCmd, StAddr, StData};
  assign last_gap    = gap_cnt_q == GapW'(CS_IDLE - 1);
  assign unused_addr = ^bus.req_addr[1:0];

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .en_i      (shifting),
    .sck_o     (flash_clk_o),
    .rise_stb_o(rise_stb),
    .fall_stb_o(fall_stb)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: phase changes happen on the SCK fall that ends each field
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCmd;
      StCmd:   if (fall_stb && bit_cnt_q == LAST_CMD_BIT) state_d = StAddr;
      StAddr:  if (fall_stb && bit_cnt_q == LAST_ADDR_BIT) state_d = StData;
      StData:  if (fall_stb && bit_cnt_q == LAST_DATA_BIT) state_d = StDone;
      StDone:  state_d = StGap;
      StGap:   if (last_gap) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: TX shifter doubles as MOSI register and zero-fills after the address
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      csb_q      <= 1'b1;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rsp_data_q <= '0;
    end else begin
      csb_q <= !(state_d inside {StCmd, StAddr, StData});
      if (accept) begin
        tx_q      <= {FLASH_CMD_READ, bus.req_addr[23:2], 2'b00};
        bit_cnt_q <= '0;
      end else if (fall_stb) begin
        tx_q      <= {tx_q[30:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
      end
      if (rise_stb && state_q == StData) begin
        rx_q <= {rx_q[30:0], flash_miso_i};
      end
      if (state_q == StData && state_d == StDone) begin
        rsp_data_q <= bswap32(rx_q);
      end
      if (state_q != StGap) begin
        gap_cnt_q <= '0;
      end else if (!last_gap) begin
        gap_cnt_q <= gap_cnt_q + GapW'(1);
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.rsp_valid = (state_q == StDone);
  assign bus.rsp_data  = rsp_data_q;
  assign flash_csb_o   = csb_q;
  assign flash_mosi_o  = tx_q[31];

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Bench for spi_flash_rd_ctrl: flash model, scoreboard, vector table and corner sequences.
module tb_spi_flash_rd_ctrl;

  typedef struct {
    logic [23:0] addr;
    logic [31:0] cmdaddr;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] cmdaddr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;           // 0: CLK_DIV=2 instance, 1: CLK_DIV=1 instance
  logic        req_valid = 1'b0;
  logic [23:0] req_addr = '0;
  logic        miso = 1'b0;
  int          cyc = 0;

  logic csb2, sck2, mosi2, csb1, sck1, mosi1;

  spi_flash_rd_ctrl_if if2 ();
  spi_flash_rd_ctrl_if if1 ();

  assign if2.req_valid = req_valid && !sel;
  assign if2.req_addr  = req_addr;
  assign if1.req_valid = req_valid && sel;
  assign if1.req_addr  = req_addr;

  spi_flash_rd_ctrl #(.CLK_DIV(2), .CS_IDLE(4)) u_dut2 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .bus         (if2.slave),
    .flash_csb_o (csb2),
    .flash_clk_o (sck2),
    .flash_mosi_o(mosi2),
    .flash_miso_i(miso)
  );

  spi_flash_rd_ctrl #(.CLK_DIV(1), .CS_IDLE(4)) u_dut1 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .bus         (if1.slave),
    .flash_csb_o (csb1),
    .flash_clk_o (sck1),
    .flash_mosi_o(mosi1),
    .flash_miso_i(miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // View of whichever instance is under test
  logic        m_csb, m_sck, m_mosi, m_ready, m_rsp_valid, m_busy;
  logic [31:0] m_rsp_data;
  int          cur_div;
  assign m_csb       = sel ? csb1 : csb2;
  assign m_sck       = sel ? sck1 : sck2;
  assign m_mosi      = sel ? mosi1 : mosi2;
  assign m_ready     = sel ? if1.req_ready : if2.req_ready;
  assign m_rsp_valid = sel ? if1.rsp_valid : if2.rsp_valid;
  assign m_busy      = sel ? if1.busy : if2.busy;
  assign m_rsp_data  = sel ? if1.rsp_data : if2.rsp_data;
  assign cur_div     = sel ? 1 : 2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flash contents: byte at address a
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    logic [7:0] t, p;
    t = a[7:0] + 8'd1;
    p = t * 8'h11;
    return p ^ a[23:16];
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [23:0] b;
    b = {a[23:2], 2'b00};
    return {fbyte(b + 24'd3), fbyte(b + 24'd2), fbyte(b + 24'd1), fbyte(b)};
  endfunction

  // Mode-0 flash model: captures command/address on SCK rise, drives data after SCK fall
  int          fl_cnt = 0;
  int          fl_rises = 0;
  logic [31:0] fl_cmdaddr = '0;
  logic [31:0] fl_data = '0;

  always @(negedge m_csb) begin
    fl_cnt = 0;
    fl_rises = 0;
    fl_cmdaddr = '0;
    miso = 1'b0;
  end

  always @(posedge m_sck) begin
    if (!m_csb) begin
      if (fl_cnt < 32) fl_cmdaddr = {fl_cmdaddr[30:0], m_mosi};
      fl_cnt++;
      fl_rises++;
      if (fl_cnt == 32) begin
        fl_data = {fbyte(fl_cmdaddr[23:0]), fbyte(fl_cmdaddr[23:0] + 24'd1),
                   fbyte(fl_cmdaddr[23:0] + 24'd2), fbyte(fl_cmdaddr[23:0] + 24'd3)};
      end
    end
  end

  always @(negedge m_sck) begin
    if (!m_csb && fl_cnt >= 32 && fl_cnt < 64) miso = fl_data[63-fl_cnt];
  end

  // Scoreboard and bus monitor, sampled mid-cycle
  exp_t exp_q[$];
  int   acc_q[$];
  int   acc_log[$];
  int   n_rsp = 0;
  int   csb_low = 0;
  int   hi_run = 0;
  int   last_hi_run = 0;
  int   idle_bad = 0;
  exp_t mon_e;
  int   mon_a;

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && m_ready) begin
        acc_q.push_back(cyc);
        acc_log.push_back(cyc);
        csb_low = 0;
      end
      if (!m_csb) begin
        csb_low++;
        if (hi_run > 0) last_hi_run = hi_run;
        hi_run = 0;
      end else begin
        hi_run++;
      end
      if (m_csb && (m_sck || m_mosi)) idle_bad++;
      if (m_rsp_valid) begin
        n_rsp++;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got data %h with no request outstanding", m_rsp_data);
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = acc_q.pop_front();
          check("rsp_data", 64'(m_rsp_data), 64'(mon_e.data));
          check("rsp_latency", 64'(cyc - mon_a), 64'(1 + 128 * cur_div));
          check("mosi_cmd_addr", 64'(fl_cmdaddr), 64'(mon_e.cmdaddr));
          check("sck_rises", 64'(fl_rises), 64'd64);
          check("csb_low_cycles", 64'(csb_low), 64'(128 * cur_div));
        end
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!m_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 64'(m_ready), 64'd1);
  endtask

  task automatic push_exp(input logic [31:0] data, input logic [31:0] cmdaddr);
    exp_t e;
    e.data = data;
    e.cmdaddr = cmdaddr;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [23:0] addr, input logic [31:0] cmdaddr,
                      input logic [31:0] data);
    push_exp(data, cmdaddr);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = addr;
    wait_accept();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (n_rsp < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("rsp_timeout", 64'(n_rsp >= target), 64'd1);
  endtask

  task automatic wait_fl_cnt(input int target);
    int n = 0;
    while (fl_cnt < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("flash_progress_timeout", 64'(fl_cnt >= target), 64'd1);
  endtask

  vec_t vecs[4];

  initial begin
    int tgt;
    int n_acc_before;
    logic [23:0] a1, a2;

    vecs[0] = '{addr: 24'h000100, cmdaddr: 32'h03000100, data: 32'h44332211};
    vecs[1] = '{addr: 24'h123457, cmdaddr: 32'h03123454, data: 32'hCAD5A4B7};
    vecs[2] = '{addr: 24'hFFFFFF, cmdaddr: 32'h03FFFFFC, data: 32'hFF102132};
    vecs[3] = '{addr: 24'hA5A5A6, cmdaddr: 32'h03A5A5A4, data: 32'h8DB2A350};

    repeat (3) @(negedge clk);
    check("reset_pads", 64'({m_csb, m_sck, m_mosi}), 64'b100);
    check("reset_ctrl", 64'({m_rsp_valid, m_busy, m_ready}), 64'b001);
    check("reset_rsp_data", 64'(m_rsp_data), 64'd0);
    #1 rst_n = 1'b1;

    // Table-driven reads at CLK_DIV=2
    for (int i = 0; i < 4; i++) begin
      tgt = n_rsp + 1;
      send(vecs[i].addr, vecs[i].cmdaddr, vecs[i].data);
      wait_rsp(tgt);
      repeat (5) @(negedge clk);
      check("rsp_data_hold", 64'({m_rsp_valid, m_rsp_data}), 64'({1'b0, vecs[i].data}));
    end

    // Back-to-back with req_valid held high
    a1 = 24'h001000;
    a2 = 24'h00ABCD;
    tgt = n_rsp + 2;
    push_exp(exp_word(a1), {8'h03, a1[23:2], 2'b00});
    push_exp(exp_word(a2), {8'h03, a2[23:2], 2'b00});
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = a1;
    wait_accept();
    @(posedge clk);
    #1;
    req_addr = a2;
    wait_accept();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_rsp(tgt);
    check("b2b_accept_spacing",
          64'(acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2]), 64'd262);
    check("b2b_csb_high_gap", 64'(last_hi_run), 64'd6);

    // Request pulse while busy in DATA is ignored
    a1 = 24'h000300;
    tgt = n_rsp + 1;
    send(a1, {8'h03, a1}, exp_word(a1));
    wait_fl_cnt(40);
    n_acc_before = acc_log.size();
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = 24'h000400;
    @(negedge clk);
    check("busy_ready_low", 64'({m_ready, m_busy}), 64'b01);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_rsp(tgt);
    repeat (300) @(negedge clk);
    check("busy_no_extra_txn", 64'({acc_log.size() == n_acc_before, m_busy, m_csb}), 64'b101);

    // Asynchronous reset in the middle of the address phase
    a1 = 24'h000200;
    send(a1, {8'h03, a1}, exp_word(a1));
    wait_fl_cnt(14);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_pads", 64'({m_csb, m_sck, m_mosi}), 64'b100);
    check("async_reset_ctrl", 64'({m_rsp_valid, m_busy, m_ready}), 64'b001);
    check("async_reset_rsp_data", 64'(m_rsp_data), 64'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    tgt = n_rsp;
    repeat (300) @(negedge clk);
    check("abort_no_rsp", 64'(n_rsp), 64'(tgt));
    tgt = n_rsp + 1;
    send(vecs[1].addr, vecs[1].cmdaddr, vecs[1].data);
    wait_rsp(tgt);

    // CLK_DIV=1 instance
    sel = 1'b1;
    repeat (3) @(negedge clk);
    tgt = n_rsp + 1;
    send(vecs[0].addr, vecs[0].cmdaddr, vecs[0].data);
    wait_rsp(tgt);

    repeat (10) @(negedge clk);
    check("idle_pads_quiet", 64'(idle_bad), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
    $fatal(1);
  end

endmodule
